status_reg: RTL and testbench

//  6502 processor status register (P): the consumer end of the ALU sr_data flag bus.

---
 rtl/status_reg_pkg.sv | 50 +++++
 rtl/branch_eval.sv | 30 +++
 rtl/status_reg.sv | 80 ++++++++
 tb/tb_status_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/status_reg_pkg.sv
// Shared definitions for the 6502 status register: flag bit positions,
// flag-operation and branch-select encodings, and storage helpers.
package status_reg_pkg;

  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_I = 2;
  localparam int SR_D = 3;
  localparam int SR_B = 4;
  localparam int SR_5 = 5;
  localparam int SR_V = 6;
  localparam int SR_N = 7;

  // Bits the ALU flag bus may write: N, V, Z, C.
  localparam logic [7:0] ALU_MASK = 8'hC3;

  typedef enum logic [1:0] {
    FOP_NONE = 2'b00,
    FOP_SET  = 2'b01,
    FOP_CLR  = 2'b10,
    FOP_RSVD = 2'b11
  } flag_op_e;

  typedef enum logic [1:0] {
    BR_N = 2'b00,
    BR_V = 2'b01,
    BR_C = 2'b10,
    BR_Z = 2'b11
  } br_sel_e;

  // B has no storage and bit 5 is hard-wired high.
  function automatic logic [7:0] fix_p(input logic [7:0] p);
    logic [7:0] r;
    r       = p;
    r[SR_5] = 1'b1;
    r[SR_B] = 1'b0;
    return r;
  endfunction

  // Only C, I, D and V have SEx/CLx instructions.
  function automatic logic flag_writable(input logic [2:0] sel);
    logic ok;
    case (int'(sel))
      SR_C, SR_I, SR_D, SR_V: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation: picks N, V, C or Z by opcode bits [7:6]
// and compares it against the expected value in bit 5.
module branch_eval
  import status_reg_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic [7:0] sr,
  output logic       br_take
);

  logic flag;
  logic unused_bits;

  assign unused_bits = ^sr[5:2];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    flag = 1'b0;
    case (br_sel_e'(br_cond[2:1]))
      BR_N:    flag = sr[SR_N];
      BR_V:    flag = sr[SR_V];
      BR_C:    flag = sr[SR_C];
      BR_Z:    flag = sr[SR_Z];
      default: flag = 1'b0;
    endcase
  end

  assign br_take = (flag == br_cond[0]);

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register: ALU flag merge, SEx/CLx, PLP/RTI pull,
// interrupt-entry I set, push byte formation, branch test and delayed IRQ mask.
module status_reg
  import status_reg_pkg::*;
#(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] alu_sr,
  input  logic       upd_en,
  input  logic [7:0] upd_mask,
  input  logic [1:0] flag_op,
  input  logic [2:0] flag_sel,
  input  logic       pull_en,
  input  logic [7:0] pull_data,
  input  logic       int_set_i,
  input  logic       push_brk,
  input  logic [2:0] br_cond,
  output logic [7:0] sr,
  output logic [7:0] push_data,
  output logic       br_take,
  output logic       irq_mask
);

  logic [7:0] sr_q;
  logic [7:0] p_next;
  logic [7:0] merge_mask;
  logic       irq_mask_q;

  assign merge_mask = upd_mask & ALU_MASK;

  // Later assignments override earlier ones, so sources are applied
  // lowest priority first; a pull replaces everything.
  always_comb begin
    p_next = sr_q;
    if (pull_en) begin
      p_next = pull_data;
    end else begin
      if (upd_en) begin
        p_next = (p_next & ~merge_mask) | (alu_sr & merge_mask);
      end
      if (flag_writable(flag_sel)) begin
        case (flag_op_e'(flag_op))
          FOP_SET: p_next[flag_sel] = 1'b1;
          FOP_CLR: p_next[flag_sel] = 1'b0;
          default: ;
        endcase
      end
      if (int_set_i) begin
        p_next[SR_I] = 1'b1;
      end
    end
    p_next = fix_p(p_next);
  end

  // irq_mask samples the registered I, giving the one-cycle CLI/SEI/PLP poll lag.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= fix_p(RESET_P);
      irq_mask_q <= 1'b1;
    end else if (ce) begin
      sr_q       <= p_next;
      irq_mask_q <= sr_q[SR_I];
    end
  end

  assign sr        = sr_q;
  assign irq_mask  = irq_mask_q;
  assign push_data = {sr_q[SR_N], sr_q[SR_V], 1'b1, push_brk, sr_q[3:0]};

  branch_eval u_branch_eval (
    .br_cond (br_cond),
    .sr      (sr_q),
    .br_take (br_take)
  );

endmodule

// File: tb/tb_status_reg.sv
// Directed, table-driven bench for status_reg plus hand-written sequences
// for IRQ-mask latency, stall and branch-condition sweep.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [7:0] alu_sr;
  logic       upd_en;
  logic [7:0] upd_mask;
  logic [1:0] flag_op;
  logic [2:0] flag_sel;
  logic       pull_en;
  logic [7:0] pull_data;
  logic       int_set_i;
  logic       push_brk;
  logic [2:0] br_cond;
  logic [7:0] sr;
  logic [7:0] push_data;
  logic       br_take;
  logic       irq_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  status_reg #(.RESET_P(8'h24)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .alu_sr    (alu_sr),
    .upd_en    (upd_en),
    .upd_mask  (upd_mask),
    .flag_op   (flag_op),
    .flag_sel  (flag_sel),
    .pull_en   (pull_en),
    .pull_data (pull_data),
    .int_set_i (int_set_i),
    .push_brk  (push_brk),
    .br_cond   (br_cond),
    .sr        (sr),
    .push_data (push_data),
    .br_take   (br_take),
    .irq_mask  (irq_mask)
  );

  typedef struct {
    logic       rst;
    logic       ce;
    logic       upd;
    logic [7:0] mask;
    logic [7:0] alu;
    logic [1:0] fop;
    logic [2:0] fsel;
    logic       pull;
    logic [7:0] pdata;
    logic       intr;
    logic       brk;
    logic [7:0] exp_sr;
    logic       exp_irq;
    logic       exp_br;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset     = v.rst;
    ce        = v.ce;
    upd_en    = v.upd;
    upd_mask  = v.mask;
    alu_sr    = v.alu;
    flag_op   = v.fop;
    flag_sel  = v.fsel;
    pull_en   = v.pull;
    pull_data = v.pdata;
    int_set_i = v.intr;
    push_brk  = v.brk;
  endtask

  task automatic idle();
    reset = 0; ce = 1; upd_en = 0; upd_mask = 0; alu_sr = 0; flag_op = 0;
    flag_sel = 0; pull_en = 0; pull_data = 0; int_set_i = 0; push_brk = 0;
  endtask

  // Apply the current inputs across one rising edge, then let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    br_cond = 3'd0;  // BPL: taken when N == 0

    //         rst ce upd mask   alu    fop   fsel  pull pdata  int brk  sr     irq  br
    vecs[0]  = '{1, 1, 0, 8'h00, 8'h00, 2'd0, 3'd0, 1, 8'hFF, 0, 0, 8'h24, 1, 1};
    vecs[1]  = '{1, 0, 0, 8'h00, 8'h00, 2'd0, 3'd0, 1, 8'hFF, 0, 1, 8'h24, 1, 1};
    vecs[2]  = '{0, 1, 1, 8'hC3, 8'hC3, 2'd0, 3'd0, 0, 8'h00, 0, 0, 8'hE7, 1, 0};
    vecs[3]  = '{0, 1, 1, 8'h02, 8'h00, 2'd0, 3'd0, 0, 8'h00, 0, 0, 8'hE5, 1, 0};
    vecs[4]  = '{1, 1, 0, 8'h00, 8'h00, 2'd0, 3'd0, 0, 8'h00, 0, 0, 8'h24, 1, 1};
    vecs[5]  = '{0, 1, 1, 8'h01, 8'h00, 2'd1, 3'd0, 0, 8'h00, 0, 0, 8'h25, 1, 1};
    vecs[6]  = '{0, 1, 0, 8'h00, 8'h00, 2'd2, 3'd2, 1, 8'hFF, 0, 1, 8'hEF, 1, 0};
    vecs[7]  = '{0, 0, 0, 8'h00, 8'h00, 2'd2, 3'd0, 0, 8'h00, 0, 1, 8'hEF, 1, 0};
    vecs[8]  = '{0, 1, 0, 8'h00, 8'h00, 2'd2, 3'd1, 0, 8'h00, 0, 0, 8'hEF, 1, 0};
    vecs[9]  = '{0, 1, 0, 8'h00, 8'h00, 2'd2, 3'd7, 0, 8'h00, 0, 0, 8'hEF, 1, 0};
    vecs[10] = '{0, 1, 0, 8'h00, 8'h00, 2'd2, 3'd3, 0, 8'h00, 0, 0, 8'hE7, 1, 0};
    vecs[11] = '{0, 1, 1, 8'hC3, 8'h00, 2'd2, 3'd2, 0, 8'h00, 1, 0, 8'h24, 1, 1};
    vecs[12] = '{0, 1, 1, 8'h40, 8'h00, 2'd1, 3'd6, 0, 8'h00, 0, 0, 8'h64, 1, 1};
    vecs[13] = '{0, 1, 0, 8'h00, 8'h00, 2'd3, 3'd0, 0, 8'h00, 0, 0, 8'h64, 1, 1};
    vecs[14] = '{0, 1, 0, 8'h00, 8'h00, 2'd0, 3'd0, 1, 8'h00, 0, 0, 8'h20, 1, 1};
    vecs[15] = '{0, 1, 0, 8'h00, 8'h00, 2'd0, 3'd0, 0, 8'h00, 0, 0, 8'h20, 0, 1};
    vecs[16] = '{0, 1, 0, 8'h00, 8'h00, 2'd0, 3'd0, 0, 8'h00, 1, 0, 8'h24, 0, 1};
    vecs[17] = '{1, 1, 0, 8'h00, 8'h00, 2'd0, 3'd0, 1, 8'hFF, 0, 0, 8'h24, 1, 1};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      tick();
      check($sformatf("v%0d sr", i), sr, vecs[i].exp_sr);
      check($sformatf("v%0d irq_mask", i), {7'd0, irq_mask}, {7'd0, vecs[i].exp_irq});
      check($sformatf("v%0d push_data", i), push_data,
            vecs[i].exp_sr | (vecs[i].brk ? 8'h10 : 8'h00));
      check($sformatf("v%0d br_take", i), {7'd0, br_take}, {7'd0, vecs[i].exp_br});
    end

    // CLI latency: mask lifts one enabled cycle after I clears.
    @(negedge clk); idle(); reset = 1; tick();
    @(negedge clk); idle(); flag_op = 2'd2; flag_sel = 3'd2; tick();
    check("cli t+1 sr", sr, 8'h20);
    check("cli t+1 irq_mask", {7'd0, irq_mask}, 8'h01);
    @(negedge clk); idle(); tick();
    check("cli t+2 irq_mask", {7'd0, irq_mask}, 8'h00);

    // SEI latency: one more poll sees the mask clear.
    @(negedge clk); idle(); flag_op = 2'd1; flag_sel = 3'd2; tick();
    check("sei t+1 sr", sr, 8'h24);
    check("sei t+1 irq_mask", {7'd0, irq_mask}, 8'h00);
    @(negedge clk); idle(); tick();
    check("sei t+2 irq_mask", {7'd0, irq_mask}, 8'h01);

    // CLI followed by a stall: irq_mask holds until the next enabled edge.
    @(negedge clk); idle(); reset = 1; tick();
    @(negedge clk); idle(); flag_op = 2'd2; flag_sel = 3'd2; tick();
    @(negedge clk); idle(); ce = 0; tick();
    check("stall sr", sr, 8'h20);
    check("stall irq_mask", {7'd0, irq_mask}, 8'h01);
    @(negedge clk); idle(); tick();
    check("after stall irq_mask", {7'd0, irq_mask}, 8'h00);

    // Branch sweep with N, Z, C set (bit 5 always reads 1).
    @(negedge clk); idle(); pull_en = 1; pull_data = 8'h83; tick();
    check("pull 83 sr", sr, 8'hA3);
    @(negedge clk); idle();
    for (int c = 0; c < 8; c++) begin
      logic [7:0] exp_take;
      exp_take = 8'b1010_0110;
      br_cond = 3'(c);
      #1;
      check($sformatf("br_cond %0d", c), {7'd0, br_take}, {7'd0, exp_take[c]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
